reorder_buffer: RTL and testbench

- Downstream of the rename stage: accepts up to two renamed instructions per cycle, tracks completion, and retires up to two per cycle in program order.
- On retirement it returns each instruction's previous physical mapping (p_old_rd) to the free pool as a 64-bit release mask.
- Circular buffer with head/tail pointers. Entries are tagged by ROB index for writeback.

---
 rtl/rob_pkg.sv | 37 +++
 rtl/reorder_buffer_if.sv | 62 ++++++
 rtl/reorder_buffer.sv | 150 +++++++++++++++
 tb/tb_reorder_buffer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared types and sizing for the reorder buffer.
// Optional flush support is enabled with ROB_FLUSH_EN.
package rob_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int NUM_PHYSICAL_REGISTERS = 64;
  localparam int PREG_W = 6;
  localparam int TAG_W = $clog2(ROB_DEPTH);

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [TAG_W-1:0] rob_tag_t;
  typedef logic [TAG_W:0] rob_ptr_t;
  typedef logic [4:0] areg_t;
  typedef logic [NUM_PHYSICAL_REGISTERS-1:0] rel_mask_t;

  localparam areg_t ARCH_REG_ZERO = 5'd0;

  typedef struct packed {
    logic  valid;
    logic  done;
    areg_t rd;
    preg_t p_rd;
    preg_t p_old_rd;
  } rob_entry_t;

  // x0 never owns a physical register, and p0 is never recycled
  function automatic rel_mask_t free_bit(
    input areg_t rd,
    input preg_t p
  );
    free_bit = '0;
    if (rd != ARCH_REG_ZERO)
      free_bit[p] = 1'b1;
    free_bit[0] = 1'b0;
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Rename/writeback/commit bundle of the reorder buffer.
// master = rename side driver, slave = the buffer itself.
interface reorder_buffer_if;
  import rob_pkg::*;

  logic [1:0] alloc_valid;
  areg_t      instr1_rd;
  areg_t      instr2_rd;
  preg_t      instr1_p_rd;
  preg_t      instr2_p_rd;
  preg_t      instr1_p_old_rd;
  preg_t      instr2_p_old_rd;
  logic       alloc_ready;
  rob_tag_t   instr1_tag;
  rob_tag_t   instr2_tag;

  logic [1:0] wb_valid;
  rob_tag_t   wb_tag0;
  rob_tag_t   wb_tag1;

  logic [1:0] commit_valid;
  areg_t      commit_rd0;
  areg_t      commit_rd1;
  preg_t      commit_p_rd0;
  preg_t      commit_p_rd1;
  rel_mask_t  release_mask;
  logic       empty;
  logic       full;

  modport master (
    output alloc_valid,
    output instr1_rd, instr2_rd,
    output instr1_p_rd, instr2_p_rd,
    output instr1_p_old_rd,
    output instr2_p_old_rd,
    input  alloc_ready,
    input  instr1_tag, instr2_tag,
    output wb_valid, wb_tag0, wb_tag1,
    input  commit_valid,
    input  commit_rd0, commit_rd1,
    input  commit_p_rd0, commit_p_rd1,
    input  release_mask,
    input  empty, full
  );

  modport slave (
    input  alloc_valid,
    input  instr1_rd, instr2_rd,
    input  instr1_p_rd, instr2_p_rd,
    input  instr1_p_old_rd,
    input  instr2_p_old_rd,
    output alloc_ready,
    output instr1_tag, instr2_tag,
    input  wb_valid, wb_tag0, wb_tag1,
    output commit_valid,
    output commit_rd0, commit_rd1,
    output commit_p_rd0, commit_p_rd1,
    output release_mask,
    output empty, full
  );

endinterface

// File: rtl/reorder_buffer.sv
// Two-wide in-order retirement buffer with p_old_rd release mask.
// Define ROB_FLUSH_EN to add a synchronous flush input.
module reorder_buffer
  import rob_pkg::*;
(
  input logic clk,
  input logic reset,
`ifdef ROB_FLUSH_EN
  input logic flush,
`endif
  reorder_buffer_if.slave rob
);

  rob_entry_t ent [ROB_DEPTH];
  rob_ptr_t   head;
  rob_ptr_t   tail;
  rob_ptr_t   count;

  logic       ready;
  logic       clr;
  logic [1:0] take;
  rob_tag_t   t1;
  rob_tag_t   t2;
  rob_tag_t   h0;
  rob_tag_t   h1;
  logic       ret0;
  logic       ret1;
  rob_ptr_t   n_alloc;
  rob_ptr_t   n_ret;
  rel_mask_t  rel;

`ifdef ROB_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  // readiness ignores this cycle's retirement on purpose
  assign ready =
    (rob_ptr_t'(ROB_DEPTH) - count)
      > rob_ptr_t'(1);

  assign rob.alloc_ready = ready;
  assign rob.full =
    count == rob_ptr_t'(ROB_DEPTH);
  assign rob.empty = head == tail;

  assign t1 = tail[TAG_W-1:0];
  assign t2 = t1
    + rob_tag_t'(rob.alloc_valid[0]);
  assign rob.instr1_tag = t1;
  assign rob.instr2_tag = t2;

  assign take = ready
    ? rob.alloc_valid : 2'b00;

  assign h0 = head[TAG_W-1:0];
  assign h1 = h0 + rob_tag_t'(1);

  assign ret0 = ent[h0].valid
    & ent[h0].done;
  assign ret1 = ret0
    & ent[h1].valid
    & ent[h1].done;

  assign n_alloc = rob_ptr_t'(take[0])
    + rob_ptr_t'(take[1]);
  assign n_ret = rob_ptr_t'(ret0)
    + rob_ptr_t'(ret1);

  always_comb begin
    rel = '0;
    if (ret0)
      rel = rel | free_bit(
        ent[h0].rd, ent[h0].p_old_rd);
    if (ret1)
      rel = rel | free_bit(
        ent[h1].rd, ent[h1].p_old_rd);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ROB_DEPTH; i++)
        ent[i] <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      rob.commit_valid <= '0;
      rob.commit_rd0 <= '0;
      rob.commit_rd1 <= '0;
      rob.commit_p_rd0 <= '0;
      rob.commit_p_rd1 <= '0;
      rob.release_mask <= '0;
    end else if (clr) begin
      for (int i = 0; i < ROB_DEPTH; i++)
        ent[i] <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      rob.commit_valid <= '0;
      rob.commit_rd0 <= '0;
      rob.commit_rd1 <= '0;
      rob.commit_p_rd0 <= '0;
      rob.commit_p_rd1 <= '0;
      rob.release_mask <= '0;
    end else begin
      // later writes win: retire clears override a late done
      if (rob.wb_valid[0]
          && ent[rob.wb_tag0].valid)
        ent[rob.wb_tag0].done <= 1'b1;
      if (rob.wb_valid[1]
          && ent[rob.wb_tag1].valid)
        ent[rob.wb_tag1].done <= 1'b1;
      if (ret0)
        ent[h0] <= '0;
      if (ret1)
        ent[h1] <= '0;
      if (take[0])
        ent[t1] <= '{
          valid:    1'b1,
          done:     1'b0,
          rd:       rob.instr1_rd,
          p_rd:     rob.instr1_p_rd,
          p_old_rd: rob.instr1_p_old_rd
        };
      if (take[1])
        ent[t2] <= '{
          valid:    1'b1,
          done:     1'b0,
          rd:       rob.instr2_rd,
          p_rd:     rob.instr2_p_rd,
          p_old_rd: rob.instr2_p_old_rd
        };
      head <= head + n_ret;
      tail <= tail + n_alloc;
      count <= count + n_alloc - n_ret;
      rob.commit_valid <= {ret1, ret0};
      rob.commit_rd0 <=
        ret0 ? ent[h0].rd : '0;
      rob.commit_p_rd0 <=
        ret0 ? ent[h0].p_rd : '0;
      rob.commit_rd1 <=
        ret1 ? ent[h1].rd : '0;
      rob.commit_p_rd1 <=
        ret1 ? ent[h1].p_rd : '0;
      rob.release_mask <= rel;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Random + directed bench for reorder_buffer against a queue model.
// Define ROB_FLUSH_EN to exercise the flush input as well.
module tb_reorder_buffer;
  import rob_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush_s = 1'b0;

  always #5 clk = ~clk;

  reorder_buffer_if bif ();

  reorder_buffer dut (
    .clk   (clk),
    .reset (reset),
`ifdef ROB_FLUSH_EN
    .flush (flush_s),
`endif
    .rob   (bif)
  );

  typedef struct {
    int    tag;
    areg_t rd;
    preg_t prd;
    preg_t pold;
    bit    done;
  } m_t;

  m_t   q[$];
  int   nt;
  int   issued;
  bit   wrap_seen;
  int   checks = 0;
  int   failures = 0;

  logic [1:0] e_cv;
  areg_t      e_rd0, e_rd1;
  preg_t      e_prd0, e_prd1;
  rel_mask_t  e_rel;

  task automatic chk(
    input string nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    bif.alloc_valid = 2'b00;
    bif.wb_valid = 2'b00;
    bif.wb_tag0 = '0;
    bif.wb_tag1 = '0;
    flush_s = 1'b0;
  endtask

  task automatic set_alloc(
    input logic [1:0] av,
    input areg_t r1, input preg_t p1, input preg_t o1,
    input areg_t r2, input preg_t p2, input preg_t o2
  );
    bif.alloc_valid = av;
    bif.instr1_rd = r1;
    bif.instr1_p_rd = p1;
    bif.instr1_p_old_rd = o1;
    bif.instr2_rd = r2;
    bif.instr2_p_rd = p2;
    bif.instr2_p_old_rd = o2;
  endtask

  task automatic push(
    input areg_t r, input preg_t p, input preg_t o
  );
    m_t e;
    e.tag = nt;
    e.rd = r;
    e.prd = p;
    e.pold = o;
    e.done = 1'b0;
    if (nt == 0 && issued > 0)
      wrap_seen = 1'b1;
    q.push_back(e);
    issued++;
    nt = (nt + 1) % ROB_DEPTH;
  endtask

  function automatic rel_mask_t frees(m_t e);
    rel_mask_t m;
    m = '0;
    if (e.rd != 0 && e.pold != 0)
      m[e.pold] = 1'b1;
    return m;
  endfunction

  // What the buffer must do at the coming edge, from program order
  task automatic model_edge();
    bit rdy, r0, r1;
    rdy = (ROB_DEPTH - q.size()) >= 2;
    r0 = q.size() > 0 && q[0].done;
    r1 = r0 && q.size() > 1 && q[1].done;
    e_cv = {r1, r0};
    e_rel = '0;
    if (r0) begin
      e_rd0 = q[0].rd;
      e_prd0 = q[0].prd;
      e_rel |= frees(q[0]);
    end
    if (r1) begin
      e_rd1 = q[1].rd;
      e_prd1 = q[1].prd;
      e_rel |= frees(q[1]);
    end
    foreach (q[i]) begin
      if ((bif.wb_valid[0] && q[i].tag == int'(bif.wb_tag0))
       || (bif.wb_valid[1] && q[i].tag == int'(bif.wb_tag1)))
        q[i].done = 1'b1;
    end
    if (r0) void'(q.pop_front());
    if (r1) void'(q.pop_front());
    if (rdy && !flush_s) begin
      if (bif.alloc_valid[0])
        push(bif.instr1_rd, bif.instr1_p_rd,
             bif.instr1_p_old_rd);
      if (bif.alloc_valid[1])
        push(bif.instr2_rd, bif.instr2_p_rd,
             bif.instr2_p_old_rd);
    end
    if (flush_s) begin
      q.delete();
      nt = 0;
      e_cv = 2'b00;
      e_rel = '0;
    end
  endtask

  // Called at a negedge with inputs applied; ends at the next negedge
  task automatic step();
    int t2;
    #1;
    t2 = (nt + int'(bif.alloc_valid[0])) % ROB_DEPTH;
    chk("alloc_ready", bif.alloc_ready,
        64'((ROB_DEPTH - q.size()) >= 2));
    chk("full", bif.full, 64'(q.size() == ROB_DEPTH));
    chk("empty", bif.empty, 64'(q.size() == 0));
    chk("instr1_tag", bif.instr1_tag, 64'(nt));
    chk("instr2_tag", bif.instr2_tag, 64'(t2));
    model_edge();
    @(posedge clk);
    #1;
    chk("commit_valid", bif.commit_valid, e_cv);
    if (e_cv[0]) begin
      chk("commit_rd0", bif.commit_rd0, e_rd0);
      chk("commit_p_rd0", bif.commit_p_rd0, e_prd0);
    end
    if (e_cv[1]) begin
      chk("commit_rd1", bif.commit_rd1, e_rd1);
      chk("commit_p_rd1", bif.commit_p_rd1, e_prd1);
    end
    chk("release_mask", bif.release_mask, e_rel);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    #2 reset = 1'b1;
    #1;
    chk("rst_empty", bif.empty, 1);
    chk("rst_cv", bif.commit_valid, 0);
    chk("rst_rel", bif.release_mask, 0);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    nt = 0;
    issued = 0;
    wrap_seen = 1'b0;
  endtask

  function automatic rob_tag_t pick();
    if (q.size() > 0 && $urandom_range(0, 3) != 0)
      return rob_tag_t'(q[$urandom_range(0, q.size() - 1)].tag);
    return rob_tag_t'($urandom);
  endfunction

  task automatic rnd_inputs(input bit may_alloc);
    areg_t r1, r2;
    r1 = ($urandom_range(0, 5) == 0) ? '0 : areg_t'($urandom);
    r2 = ($urandom_range(0, 5) == 0) ? '0 : areg_t'($urandom);
    set_alloc(may_alloc ? 2'($urandom_range(0, 3)) : 2'b00,
              r1, preg_t'($urandom), preg_t'($urandom),
              r2, preg_t'($urandom), preg_t'($urandom));
    bif.wb_valid[0] = $urandom_range(0, 2) != 0;
    bif.wb_valid[1] = $urandom_range(0, 3) == 0;
    bif.wb_tag0 = pick();
    bif.wb_tag1 = pick();
    flush_s = 1'b0;
  endtask

  initial begin
    int cyc;
    idle();
    set_alloc(2'b00, '0, '0, '0, '0, '0, '0);
    @(negedge clk);
    do_reset();

    // single instruction through to commit
    set_alloc(2'b01, 5'd3, 6'd33, 6'd3, '0, '0, '0);
    step();
    idle();
    bif.wb_valid = 2'b01;
    bif.wb_tag0 = 4'd0;
    step();
    idle();
    step();
    chk("t1_cv", bif.commit_valid, 2'b01);
    chk("t1_prd", bif.commit_p_rd0, 33);
    chk("t1_rel", bif.release_mask, 64'h8);

    // pair retires together only once the older one is done
    do_reset();
    set_alloc(2'b11, 5'd5, 6'd40, 6'd7, 5'd6, 6'd41, 6'd8);
    step();
    idle();
    bif.wb_valid = 2'b01;
    bif.wb_tag0 = 4'd1;
    step();
    idle();
    step();
    chk("t2_wait", bif.commit_valid, 2'b00);
    bif.wb_valid = 2'b10;
    bif.wb_tag1 = 4'd0;
    step();
    idle();
    step();
    chk("t2_cv", bif.commit_valid, 2'b11);
    chk("t2_rel", bif.release_mask, 64'h180);

    // fill to full, extra request ignored
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_alloc(2'b11, 5'(i + 1), 6'(i + 10), 6'(i + 1),
                5'(i + 2), 6'(i + 20), 6'(i + 2));
      step();
    end
    idle();
    #1;
    chk("t3_full", bif.full, 1);
    chk("t3_ready", bif.alloc_ready, 0);
    @(negedge clk);
    bif.alloc_valid = 2'b11;
    step();
    idle();
    #1;
    chk("t3_tail", bif.instr1_tag, 0);
    chk("t3_still_full", bif.full, 1);
    @(negedge clk);

    // x0 destination commits but frees nothing
    do_reset();
    set_alloc(2'b01, 5'd0, 6'd20, 6'd0, '0, '0, '0);
    step();
    idle();
    bif.wb_valid = 2'b01;
    step();
    idle();
    step();
    chk("t4_cv", bif.commit_valid, 2'b01);
    chk("t4_rel", bif.release_mask, 0);

    // 40 instructions, wrapping tags, drained to empty
    do_reset();
    cyc = 0;
    while ((issued < 40 || q.size() != 0) && cyc < 800) begin
      rnd_inputs(issued < 40);
      if (issued == 39)
        bif.alloc_valid[1] = 1'b0;
      step();
      cyc++;
    end
    chk("t5_drained", 64'(cyc < 800), 1);
    chk("t5_issued", issued, 40);
    chk("t5_wrap", wrap_seen, 1);
    idle();
    #1;
    chk("t5_empty", bif.empty, 1);
    @(negedge clk);

`ifdef ROB_FLUSH_EN
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_alloc(2'b11, 5'd1, 6'd1, 6'd2, 5'd3, 6'd4, 6'd5);
      step();
    end
    set_alloc(2'b01, 5'd1, 6'd9, 6'd9, '0, '0, '0);
    bif.wb_valid = 2'b11;
    bif.wb_tag0 = 4'd3;
    bif.wb_tag1 = 4'd2;
    step();
    idle();
    flush_s = 1'b1;
    step();
    chk("fl_cv", bif.commit_valid, 0);
    chk("fl_rel", bif.release_mask, 0);
    idle();
    bif.alloc_valid = 2'b01;
    #1;
    chk("fl_empty", bif.empty, 1);
    chk("fl_tag", bif.instr1_tag, 0);
    @(negedge clk);
    idle();
`endif

    // long random soak with occasional reset mid-flight
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rnd_inputs(1'b1);
`ifdef ROB_FLUSH_EN
      flush_s = $urandom_range(0, 150) == 0;
`endif
      if ($urandom_range(0, 400) == 0)
        do_reset();
      else
        step();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
